// File: rtl/regfile_rw.sv
// Integer register file at the WB consumer end: one write port, two bypassed
// operand read ports, one committed-state debug port and a write counter.
module regfile_rw #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_cnt
);

    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
    logic [31:0]       wr_cnt_q;
    logic [31:0]       wr_cnt_d;
    logic [DATA_W-1:0] stored1_s;
    logic [DATA_W-1:0] stored2_s;
    logic [DATA_W-1:0] stored_dbg_s;

    // x0 has no storage; indices beyond NUM_REGS-1 are treated like x0.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_REGS);
    endfunction

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_i,
        input logic              re_i,
        input logic [ADDR_W-1:0] ra_i,
        input logic              we_i,
        input logic [ADDR_W-1:0] wa_i,
        input logic [DATA_W-1:0] wd_i,
        input logic [DATA_W-1:0] stored_i
    );
        logic [DATA_W-1:0] res;
        if (rst_i) begin
            res = '0;
        end else if (!re_i) begin
            res = '0;
        end else if (ra_i == '0) begin
            res = '0;
        end else if (we_i && (wa_i == ra_i)) begin
            res = wd_i;
        end else begin
            res = stored_i;
        end
        return res;
    endfunction

    // Next-state: commit WB write and bump the counter for non-zero targets.
    always_comb begin
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        if (we && addr_valid(waddr)) begin
            regs_d[waddr] = wdata;
            wr_cnt_d      = wr_cnt_q + 32'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Committed storage lookup for each read path.
    always_comb begin
        stored1_s    = '0;
        stored2_s    = '0;
        stored_dbg_s = '0;
        if (addr_valid(raddr1)) begin
            stored1_s = regs_q[raddr1];
        end else begin
            stored1_s = '0;
        end
        if (addr_valid(raddr2)) begin
            stored2_s = regs_q[raddr2];
        end else begin
            stored2_s = '0;
        end
        if (addr_valid(dbg_addr)) begin
            stored_dbg_s = regs_q[dbg_addr];
        end else begin
            stored_dbg_s = '0;
        end
    end

    // Operand ports bypass the in-flight write; debug sees committed state only.
    always_comb begin
        rdata1   = read_port(rst, re1, raddr1, we, waddr, wdata, stored1_s);
        rdata2   = read_port(rst, re2, raddr2, we, waddr, wdata, stored2_s);
        dbg_data = stored_dbg_s;
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_rw.sv
// Scoreboard bench for regfile_rw: expected outputs are queued when stimulus is
// applied and compared against the DUT at the following falling edge.
module tb_regfile_rw;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_cnt;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_cnt;
    int          tests_run;
    int          tests_failed;

    regfile_rw dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic r, input logic re_i, input logic [4:0] ra);
        if (r || !re_i || ra == 5'd0) return 32'd0;
        if (we && waddr == ra) return wdata;
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    // Called at posedge+1: apply inputs, queue expectations, compare at negedge,
    // then advance the model across the next rising edge.
    task automatic step(input string tag,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2,
                        input logic [4:0] da);
        exp_t e;
        exp_t got;
        we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2; dbg_addr = da;
        e.r1  = exp_read(rst, e1, a1);
        e.r2  = exp_read(rst, e2, a2);
        e.dbg = exp_dbg(da);
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check_eq({tag, "_rdata1"}, rdata1, got.r1);
            check_eq({tag, "_rdata2"}, rdata2, got.r2);
            check_eq({tag, "_dbg"}, dbg_data, got.dbg);
            check_eq({tag, "_wr_cnt"}, wr_cnt, got.cnt);
        end
        @(posedge clk);
        if (!rst && w && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_cnt      = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2; dbg_addr = 5'd1;
        model_clear();

        // T1: outputs zero during reset, all registers zero after.
        repeat (2) @(posedge clk);
        #1;
        we = 1'b1; waddr = 5'd1; wdata = 32'hFFFF_0000;
        #2;
        check_eq("t1_rst_rdata1", rdata1, 32'd0);
        check_eq("t1_rst_wr_cnt", wr_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            step("t1_dbg", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'(i));
        end

        // T2: write then read back.
        step("t2_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
        step("t2_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5);

        // T3: same-cycle bypass on both ports, debug lags by one edge.
        step("t3_byp", 1'b1, 5'd7, 32'h0000_1234, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
        step("t3_aft", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);

        // T4: writes to x0 are dropped and not counted.
        step("t4_x0a", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        step("t4_x0b", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);

        // T5: read enable gates the port.
        step("t5_wr", 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
        step("t5_off", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        step("t5_on", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd3);

        // Mixed traffic with frequent read/write address collisions.
        for (int n = 0; n < 300; n++) begin
            rw = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            step("rnd", 1'($urandom_range(0, 1)), rw, $urandom(),
                 ($urandom_range(0, 4) != 0), ra, ($urandom_range(0, 4) != 0), rb,
                 5'($urandom_range(0, 31)));
        end

        // T6: async reset in the cycle of a write discards it.
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b0; raddr2 = 5'd0; dbg_addr = 5'd9;
        #1;
        check_eq("t6_pre_bypass", rdata1, 32'h0000_0055);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_rdata1", rdata1, 32'd0);
        check_eq("t6_rst_wr_cnt", wr_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        step("t6_after", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd5, 5'd9);
        step("t6_wr", 1'b1, 5'd9, 32'h0000_0066, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
        step("t6_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
